// File: rtl/regfile_pkg.sv
// Shared constants and the MEM/WB bundle for the write-back stage.
// XZR_IDX is the hard-wired zero register, never written.
package regfile_pkg;

    localparam int DATA_W = 64;
    localparam int NREGS  = 32;
    localparam int ADDR_W = $clog2(NREGS);

    localparam logic [ADDR_W-1:0] XZR_IDX = ADDR_W'(31);

    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // True when the entry will land in the array at the next edge.
    function automatic logic commits(wb_entry_t e);
        return e.valid & e.regwrite & (e.rd != XZR_IDX);
    endfunction

endpackage

// File: rtl/regfile_wb_stage_if.sv
// MEM -> WB bus: pipeline control plus the result being written back.
// master = MEM stage (drives), slave = write-back stage (samples).
interface regfile_wb_stage_if;
    import regfile_pkg::*;

    logic              stall;
    logic              flush;
    logic              in_valid;
    logic              in_regwrite;
    logic [ADDR_W-1:0] in_rd;
    logic [DATA_W-1:0] in_data;

    modport master (
        output stall, flush, in_valid,
        output in_regwrite, in_rd, in_data
    );

    modport slave (
        input stall, flush, in_valid,
        input in_regwrite, in_rd, in_data
    );

endinterface

// File: rtl/regfile_wb_stage_wb_latch.sv
// MEM/WB pipeline register holding one wb_entry_t.
// Ports: clk, reset (async high), stall, flush, in_entry -> entry.
module wb_latch
    import regfile_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      stall,
    input  logic      flush,
    input  wb_entry_t in_entry,
    output wb_entry_t entry
);

    wb_entry_t entry_d;
    wb_entry_t entry_q;

    // Flush beats stall; a flushed entry keeps stale fields.
    always_comb begin
        entry_d = entry_q;
        if (flush) begin
            entry_d.valid = 1'b0;
        end else if (!stall) begin
            entry_d = in_entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry = entry_q;

endmodule

// File: rtl/regfile_wb_stage.sv
// Write-back stage: MEM/WB latch, 32x64 array, bit-sliced export.
// Ports: clk, reset (async high), mem (MEM->WB bus, slave),
//   out_bits[b][r] = bit b of reg r, wb_busy = pending write.
// Optional forwarding under macro REGFILE_WB_FWD_EN:
//   rd_addr_a/b in, fwd_a_hit/fwd_b_hit/fwd_data out.
module regfile_wb_stage
    import regfile_pkg::*;
(
    input  logic                           clk,
    input  logic                           reset,
    regfile_wb_stage_if.slave              mem,
`ifdef REGFILE_WB_FWD_EN
    input  logic [ADDR_W-1:0]              rd_addr_a,
    input  logic [ADDR_W-1:0]              rd_addr_b,
    output logic                           fwd_a_hit,
    output logic                           fwd_b_hit,
    output logic [DATA_W-1:0]              fwd_data,
`endif
    output logic [DATA_W-1:0][NREGS-1:0]   out_bits,
    output logic                           wb_busy
);

    wb_entry_t in_entry;
    wb_entry_t wb;

    logic [DATA_W-1:0] regs_d [NREGS];
    logic [DATA_W-1:0] regs_q [NREGS];

    always_comb begin
        in_entry          = '0;
        in_entry.valid    = mem.in_valid;
        in_entry.regwrite = mem.in_regwrite;
        in_entry.rd       = mem.in_rd;
        in_entry.data     = mem.in_data;
    end

    wb_latch u_wb_latch (
        .clk      (clk),
        .reset    (reset),
        .stall    (mem.stall),
        .flush    (mem.flush),
        .in_entry (in_entry),
        .entry    (wb)
    );

    assign wb_busy = commits(wb);

    // Commit uses the pre-edge latch, so a write lands one
    // edge after capture; XZR is pinned to zero.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            regs_d[r] = regs_q[r];
        end
        if (wb_busy) begin
            regs_d[wb.rd] = wb.data;
        end
        regs_d[XZR_IDX] = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
        end
    end

    // Transpose into bit-major lanes for the read-mux stage.
    always_comb begin
        out_bits = '0;
        for (int b = 0; b < DATA_W; b++) begin
            for (int r = 0; r < NREGS; r++) begin
                out_bits[b][r] = regs_q[r][b];
            end
        end
    end

`ifdef REGFILE_WB_FWD_EN
    // wb_busy already excludes XZR, so address 31 never hits.
    assign fwd_a_hit = wb_busy & (wb.rd == rd_addr_a);
    assign fwd_b_hit = wb_busy & (wb.rd == rd_addr_b);
    assign fwd_data  = wb.data;
`endif

endmodule
